// File: rtl/rx_slicer_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_slicer_aligner: hysteresis slicer + K28.5 comma hunt/lock word aligner.   |
// | Optional: RX_ALIGN_ERR_CNT_EN adds err_clr / err_total misalignment counter. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rx_slicer_aligner #(
  parameter int                LEVEL_W    = 8,
  parameter int                THRESHOLD  = 128,
  parameter int                HYST       = 8,
  parameter int                WORD_W     = 10,
  parameter logic [WORD_W-1:0] COMMA      = 10'b0011111010,
  parameter int                LOCK_CNT   = 3,
  parameter int                UNLOCK_ERR = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic               level_valid,
`ifdef RX_ALIGN_ERR_CNT_EN
  input  logic               err_clr,
  output logic [15:0]        err_total,
`endif
  output logic               bit_out,
  output logic [WORD_W-1:0]  data_out,
  output logic               data_valid,
  output logic               comma_det,
  output logic               locked
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int CC_W  = $clog2(LOCK_CNT + 1);
  localparam int EC_W  = $clog2(UNLOCK_ERR + 1);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WORD_W - 1);
  localparam logic [LEVEL_W:0] HI_BOUND = (LEVEL_W+1)'(THRESHOLD + HYST);
  localparam bit               LO_EN    = (THRESHOLD >= HYST);
  localparam logic [LEVEL_W:0] LO_BOUND = LO_EN ? (LEVEL_W+1)'(THRESHOLD - HYST) : '0;

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                bit_q, bit_d;
  logic                bit_vld_q, bit_vld_d;
  logic [WORD_W-2:0]   hist_q, hist_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CC_W-1:0]     comma_cnt_q, comma_cnt_d;
  logic [EC_W-1:0]     err_cnt_q, err_cnt_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                data_valid_q, data_valid_d;
  logic                comma_det_q, comma_det_d;

  logic [LEVEL_W:0]    lvl_ext;
  logic [WORD_W-1:0]   window;
  logic                match;
  logic                boundary;
  logic                lock_miss;
  logic [CC_W-1:0]     comma_cnt_inc;
  logic [EC_W-1:0]     err_cnt_inc;

  assign lvl_ext = {1'b0, level_in};

  always_comb begin
    bit_d     = bit_q;
    bit_vld_d = level_valid;
    if (level_valid) begin
      if (lvl_ext >= HI_BOUND) begin
        bit_d = 1'b1;
      end else if (LO_EN && (lvl_ext <= LO_BOUND)) begin
        bit_d = 1'b0;
      end
    end
  end

  // The sliced bit is registered first; the aligner consumes it one clock
  // later, paced by the delayed valid, so the two stages stay in lockstep.
  assign window        = {hist_q, bit_q};
  assign match         = (window == COMMA) || (window == ~COMMA);
  assign boundary      = (cnt_q == LAST_POS);
  assign lock_miss     = bit_vld_q && (state_q == S_LOCKED) && match && !boundary;
  assign comma_cnt_inc = comma_cnt_q + 1'b1;
  assign err_cnt_inc   = err_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    cnt_d        = cnt_q;
    comma_cnt_d  = comma_cnt_q;
    err_cnt_d    = err_cnt_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    comma_det_d  = 1'b0;
    if (bit_vld_q) begin
      hist_d = window[WORD_W-2:0];
      cnt_d  = boundary ? '0 : cnt_q + 1'b1;
      case (state_q)
        S_HUNT: begin
          if (match) begin
            cnt_d       = '0;
            comma_cnt_d = CC_W'(1);
            state_d     = S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (match && boundary) begin
            comma_det_d = 1'b1;
            comma_cnt_d = comma_cnt_inc;
            if (comma_cnt_inc == CC_W'(LOCK_CNT)) begin
              err_cnt_d = '0;
              state_d   = S_LOCKED;
            end
          end else if (match) begin
            comma_cnt_d = '0;
            state_d     = S_HUNT;
          end
        end
        S_LOCKED: begin
          if (boundary) begin
            data_d       = window;
            data_valid_d = 1'b1;
          end
          if (match && boundary) begin
            comma_det_d = 1'b1;
            err_cnt_d   = '0;
          end else if (lock_miss) begin
            err_cnt_d = err_cnt_inc;
            if (err_cnt_inc == EC_W'(UNLOCK_ERR)) begin
              comma_cnt_d = '0;
              state_d     = S_HUNT;
            end
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HUNT;
      bit_q        <= 1'b0;
      bit_vld_q    <= 1'b0;
      hist_q       <= '0;
      cnt_q        <= '0;
      comma_cnt_q  <= '0;
      err_cnt_q    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      comma_det_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      bit_vld_q    <= bit_vld_d;
      hist_q       <= hist_d;
      cnt_q        <= cnt_d;
      comma_cnt_q  <= comma_cnt_d;
      err_cnt_q    <= err_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      comma_det_q  <= comma_det_d;
    end
  end

`ifdef RX_ALIGN_ERR_CNT_EN
  logic [15:0] err_total_q, err_total_d;

  always_comb begin
    err_total_d = err_total_q;
    if (err_clr) begin
      err_total_d = '0;
    end else if (lock_miss && (err_total_q != 16'hFFFF)) begin
      err_total_d = err_total_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_total_q <= '0;
    end else begin
      err_total_q <= err_total_d;
    end
  end

  assign err_total = err_total_q;
`endif

  assign bit_out    = bit_q;
  assign data_out   = data_q;
  assign data_valid = data_valid_q;
  assign comma_det  = comma_det_q;
  assign locked     = (state_q == S_LOCKED);

endmodule
`default_nettype wire

// File: doc/rx_slicer_aligner.md
Name: rx_slicer_aligner

Overview:
- Sits directly downstream of the channel model in the RX path.
- Takes the quantised channel level (0..2^LEVEL_W-1, one sample per valid cycle) and slices it to a bit with hysteresis.
- Shifts sliced bits into a 10-bit window, hunts for the K28.5 comma, and locks the word boundary.
- Once locked, emits aligned 10-bit words to the downstream 8b/10b decoder.

Parameters:
- LEVEL_W, 8, width of channel level input.
- THRESHOLD, 128, slicer decision midpoint.
- HYST, 8, hysteresis half-band in level codes.
- WORD_W, 10, symbol width.
- COMMA, 10'b0011111010, comma pattern (RD-). Its bitwise complement is also accepted.
- LOCK_CNT, 3, consecutive on-boundary commas needed to lock.
- UNLOCK_ERR, 4, consecutive misaligned commas that force a relock.

Ports:
- clk, in, 1, sole clock.
- rst, in, 1, reset: synchronous, active-high.
- level_in, in, LEVEL_W, unsigned channel level code.
- level_valid, in, 1, level_in carries a new bit-time sample.
- bit_out, out, 1, registered sliced bit.
- data_out, out, WORD_W, aligned word; bit 9 = earliest received bit.
- data_valid, out, 1, one-cycle pulse per aligned word (LOCKED only).
- comma_det, out, 1, one-cycle pulse when an on-boundary comma is seen in VERIFY or LOCKED.
- locked, out, 1, high in LOCKED state.

Behaviour:
- Reset values (rst high at a clk edge):
  - bit_out=0, data_out=0, data_valid=0, comma_det=0, locked=0.
  - Window=0, bit counter=0, comma count=0, error count=0, state=HUNT.
  - Reset mid-word discards all partial state.
- Gating: all state advances only on cycles with level_valid=1. On other cycles state holds and data_valid/comma_det are 0.
- Slicer, 1-cycle latency:
  - level_in >= THRESHOLD+HYST gives 1.
  - level_in <= THRESHOLD-HYST gives 0.
  - Otherwise holds the previous bit.
  - Comparisons are unsigned, with bounds computed at LEVEL_W+1 bits so they cannot wrap.
- Window: {window[8:0], new_bit}. The comma check runs on the updated window in the same valid cycle. Match = (window==COMMA) or (window==~COMMA).
- Bit counter: 0..9, wraps 9 to 0 every valid cycle. "Boundary" means counter==9 on that cycle.
- HUNT:
  - Match at any position: counter forced so the current cycle is a boundary, comma count=1, go to VERIFY.
- VERIFY:
  - Boundary match: comma count+1 and comma_det=1.
  - If the count reaches LOCK_CNT, go to LOCKED with error count=0.
  - Boundary non-match: no effect.
  - Match off-boundary: go to HUNT, comma count=0.
- LOCKED:
  - Every boundary: data_out=window, data_valid=1.
  - Boundary match: comma_det=1, error count=0.
  - Off-boundary match: error count+1; on reaching UNLOCK_ERR go to HUNT and drop locked the next cycle.
  - Non-match words never affect lock.
- Simultaneous events: rst has priority over everything. data_valid and comma_det may assert in the same cycle.
- Output latency: data_out/data_valid are registered 1 clk after the valid cycle that completes the word, i.e. 2 clks after the final bit's level_in.

Optional Feature:
- Macro RX_ALIGN_ERR_CNT_EN.
- Defined:
  - Adds output err_total[15:0]: saturating count of off-boundary commas seen in LOCKED.
  - Clears on rst, holds at 16'hFFFF.
  - Also adds input err_clr (1-bit), which zeroes err_total; err_clr takes priority over an increment in the same cycle.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Slicer hysteresis: level_valid=1; levels 200, 130, 125, 119, 121, 137 -> bit_out 1, 1, 1, 0, 0, 1.
- Lock: 4 idle bits of 0, then three back-to-back 0011111010 words (levels 255/0) -> one comma_det per word in VERIFY; locked=1 after the 3rd comma; the next word 1010101010 yields data_out=10'h2AA with data_valid.
- Complement comma: three words of 1100000101 -> lock achieved, same timing as the true comma.
- Misalignment unlock: locked; inject 4 commas each shifted by 3 bits -> locked falls after the 4th. With only 3 shifted commas and then one aligned comma -> locked stays 1.
- Valid gating: locked; hold level_valid=0 for 7 cycles mid-word, then resume -> data_out unchanged, no extra data_valid, next word correct.
- Reset mid-operation: assert rst for 1 clk while locked, mid-word -> all outputs 0 next clk; relock needs 3 fresh commas. With RX_ALIGN_ERR_CNT_EN defined: err_total=0 after rst; 5 misaligned commas while locked -> err_total=4 (the 5th arrives after relock starts, in HUNT); err_clr -> 0.
